// File: rtl/router_compute_mesh.sv
// Route-compute stage for one mesh router input: XY/YX dimension order, valid/ready flit
// handshake and per-packet route lock. Define ROUTE_DST_CHECK_EN to eject out-of-mesh heads locally.
//
// state  | meaning
// IDLE   | waiting for a head flit; a non-head flit here is an orphan
// LOCKED | mid-packet; body/tail flits reuse the locked route
module router_compute_mesh #(
    parameter int MESH_X      = 4,
    parameter int MESH_Y      = 2,
    parameter int X_W         = 2,
    parameter int Y_W         = 1,
    parameter int ROUTE_ORDER = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [X_W-1:0] cur_x,
    input  logic [Y_W-1:0] cur_y,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_head,
    input  logic           in_tail,
    input  logic [X_W-1:0] dst_x,
    input  logic [Y_W-1:0] dst_y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2:0]     port,
    output logic           out_head,
    output logic           out_tail,
    output logic           err
);

    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_EAST  = 3'd1;
    localparam logic [2:0] P_WEST  = 3'd2;
    localparam logic [2:0] P_NORTH = 3'd3;
    localparam logic [2:0] P_SOUTH = 3'd4;
    localparam logic [2:0] P_EMPTY = 3'd7;

    if (MESH_X < 2 || MESH_Y < 1 || (2**X_W) < MESH_X || (2**Y_W) < MESH_Y) begin : g_bad_params
        $error("router_compute_mesh: mesh dimensions do not fit the coordinate widths");
    end

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t     state, state_next;
    logic [2:0] locked_port, locked_next;
    logic [2:0] x_port, y_port, route_port, head_port, fwd_port;
    logic       out_of_mesh, xfer_in, xfer_out, fwd, err_next;

    assign in_ready = en & (~out_valid | out_ready);
    assign xfer_in  = in_valid & in_ready;
    assign xfer_out = out_valid & out_ready;

    assign x_port = (dst_x > cur_x) ? P_EAST  : (dst_x < cur_x) ? P_WEST  : P_LOCAL;
    assign y_port = (dst_y > cur_y) ? P_NORTH : (dst_y < cur_y) ? P_SOUTH : P_LOCAL;
    assign route_port = (ROUTE_ORDER == 0) ? ((x_port != P_LOCAL) ? x_port : y_port)
                                           : ((y_port != P_LOCAL) ? y_port : x_port);

`ifdef ROUTE_DST_CHECK_EN
    assign out_of_mesh = (int'(dst_x) >= MESH_X) | (int'(dst_y) >= MESH_Y);
    assign head_port   = out_of_mesh ? P_LOCAL : route_port;
`else
    assign out_of_mesh = 1'b0;
    assign head_port   = route_port;
`endif

    // A head always (re)computes the route, even mid-packet, so a lost tail self-heals.
    always_comb begin
        state_next  = state;
        locked_next = locked_port;
        fwd         = 1'b0;
        fwd_port    = locked_port;
        err_next    = 1'b0;
        if (xfer_in) begin
            if (in_head) begin
                fwd         = 1'b1;
                fwd_port    = head_port;
                locked_next = head_port;
                state_next  = in_tail ? IDLE : LOCKED;
                err_next    = (state == LOCKED) | out_of_mesh;
            end else if (state == LOCKED) begin
                fwd = 1'b1;
                if (in_tail) begin
                    state_next  = IDLE;
                    locked_next = P_EMPTY;
                end
            end else begin
                err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            locked_port <= P_EMPTY;
            out_valid   <= 1'b0;
            port        <= P_EMPTY;
            out_head    <= 1'b0;
            out_tail    <= 1'b0;
            err         <= 1'b0;
        end else begin
            err <= err_next;
            if (en) begin
                state       <= state_next;
                locked_port <= locked_next;
                if (fwd) begin
                    out_valid <= 1'b1;
                    port      <= fwd_port;
                    out_head  <= in_head;
                    out_tail  <= in_tail;
                end else if (xfer_out) begin
                    out_valid <= 1'b0;
                    port      <= P_EMPTY;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_compute_mesh.sv
// Directed bench for router_compute_mesh: 4x2 XY, 4x2 YX and 3x2 XY instances share one stimulus.
module tb_router_compute_mesh;

    logic       clk = 1'b0;
    logic       rst_n, en, in_valid, in_head, in_tail, out_ready;
    logic [1:0] cur_x, dst_x;
    logic [0:0] cur_y, dst_y;

    logic       in_ready, out_valid, out_head, out_tail, err;
    logic [2:0] port;
    logic       yx_in_ready, yx_out_valid, yx_out_head, yx_out_tail, yx_err;
    logic [2:0] yx_port;
    logic       m3_in_ready, m3_out_valid, m3_out_head, m3_out_tail, m3_err;
    logic [2:0] m3_port;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    router_compute_mesh #(.MESH_X(4), .MESH_Y(2), .X_W(2), .Y_W(1), .ROUTE_ORDER(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cur_x(cur_x), .cur_y(cur_y),
        .in_valid(in_valid), .in_ready(in_ready), .in_head(in_head), .in_tail(in_tail),
        .dst_x(dst_x), .dst_y(dst_y), .out_valid(out_valid), .out_ready(out_ready),
        .port(port), .out_head(out_head), .out_tail(out_tail), .err(err));

    router_compute_mesh #(.MESH_X(4), .MESH_Y(2), .X_W(2), .Y_W(1), .ROUTE_ORDER(1)) dut_yx (
        .clk(clk), .rst_n(rst_n), .en(en), .cur_x(cur_x), .cur_y(cur_y),
        .in_valid(in_valid), .in_ready(yx_in_ready), .in_head(in_head), .in_tail(in_tail),
        .dst_x(dst_x), .dst_y(dst_y), .out_valid(yx_out_valid), .out_ready(out_ready),
        .port(yx_port), .out_head(yx_out_head), .out_tail(yx_out_tail), .err(yx_err));

    router_compute_mesh #(.MESH_X(3), .MESH_Y(2), .X_W(2), .Y_W(1), .ROUTE_ORDER(0)) dut_m3 (
        .clk(clk), .rst_n(rst_n), .en(en), .cur_x(cur_x), .cur_y(cur_y),
        .in_valid(in_valid), .in_ready(m3_in_ready), .in_head(in_head), .in_tail(in_tail),
        .dst_x(dst_x), .dst_y(dst_y), .out_valid(m3_out_valid), .out_ready(out_ready),
        .port(m3_port), .out_head(m3_out_head), .out_tail(m3_out_tail), .err(m3_err));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flit(input logic h, input logic t, input logic [1:0] x, input logic [0:0] y);
        in_valid = 1'b1;
        in_head  = h;
        in_tail  = t;
        dst_x    = x;
        dst_y    = y;
    endtask

    logic [1:0] vx [4] = '{2'd3, 2'd0, 2'd1, 2'd1};
    logic [0:0] vy [4] = '{1'd0, 1'd1, 1'd1, 1'd0};
    logic [2:0] vp [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
    logic [2:0] m3_exp_port;
    logic       m3_exp_err;

    initial begin
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_head = 1'b0; in_tail = 1'b0;
        out_ready = 1'b1; cur_x = 2'd1; cur_y = 1'd0; dst_x = 2'd0; dst_y = 1'd0;
        tick(); tick();
        chk("rst_port", 32'(port), 32'd7);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        #4 rst_n = 1'b1;
        #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Single-flit packets back to back, one result per cycle.
        for (int i = 0; i < 4; i++) begin
            flit(1'b1, 1'b1, vx[i], vy[i]);
            tick();
            chk($sformatf("b2b%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("b2b%0d_port", i), 32'(port), 32'(vp[i]));
            chk($sformatf("b2b%0d_tail", i), 32'(out_tail), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_port", 32'(port), 32'd7);

        cur_x = 2'd1; cur_y = 1'd1;
        flit(1'b1, 1'b1, 2'd2, 1'd0);
        tick();
        chk("xy_port", 32'(port), 32'd1);
        chk("yx_port", 32'(yx_port), 32'd4);
        in_valid = 1'b0;
        tick();

        // 4-flit packet with a downstream stall; body dst would route west if recomputed.
        cur_x = 2'd1; cur_y = 1'd0;
        flit(1'b1, 1'b0, 2'd3, 1'd0);
        tick();
        chk("pkt_head_port", 32'(port), 32'd1);
        chk("pkt_head_flag", 32'(out_head), 32'd1);
        flit(1'b0, 1'b0, 2'd0, 1'd0);
        tick();
        chk("pkt_body1_port", 32'(port), 32'd1);
        chk("pkt_body1_head", 32'(out_head), 32'd0);
        out_ready = 1'b0;
        #1 chk("pkt_stall_ready", 32'(in_ready), 32'd0);
        tick();
        chk("pkt_stall_valid", 32'(out_valid), 32'd1);
        chk("pkt_stall_port", 32'(port), 32'd1);
        out_ready = 1'b1;
        #1 chk("pkt_unstall_ready", 32'(in_ready), 32'd1);
        tick();
        chk("pkt_body2_port", 32'(port), 32'd1);
        chk("pkt_body2_tail", 32'(out_tail), 32'd0);
        flit(1'b0, 1'b1, 2'd0, 1'd0);
        tick();
        chk("pkt_tail_port", 32'(port), 32'd1);
        chk("pkt_tail_flag", 32'(out_tail), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("pkt_drain_valid", 32'(out_valid), 32'd0);

        // Orphan body right after the tail: proves the FSM went back to IDLE.
        flit(1'b0, 1'b0, 2'd3, 1'd0);
        tick();
        chk("orphan_err", 32'(err), 32'd1);
        chk("orphan_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("orphan_err_clear", 32'(err), 32'd0);

        flit(1'b1, 1'b0, 2'd3, 1'd0);
        tick();
        chk("midhead_first_err", 32'(err), 32'd0);
        flit(1'b1, 1'b0, 2'd0, 1'd0);
        tick();
        chk("midhead_err", 32'(err), 32'd1);
        chk("midhead_port", 32'(port), 32'd2);
        flit(1'b0, 1'b1, 2'd3, 1'd1);
        tick();
        chk("midhead_tail_port", 32'(port), 32'd2);
        chk("midhead_tail_err", 32'(err), 32'd0);
        in_valid = 1'b0;
        tick();

        flit(1'b1, 1'b0, 2'd3, 1'd0);
        tick();
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_port", 32'(port), 32'd7);
        #1 rst_n = 1'b1;
        flit(1'b0, 1'b1, 2'd3, 1'd0);
        tick();
        chk("post_rst_orphan_err", 32'(err), 32'd1);
        chk("post_rst_orphan_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        tick();

        flit(1'b1, 1'b1, 2'd1, 1'd1);
        tick();
        chk("en_pre_port", 32'(port), 32'd3);
        en = 1'b0;
        flit(1'b1, 1'b1, 2'd3, 1'd0);
        #1 chk("en_off_ready", 32'(in_ready), 32'd0);
        tick();
        chk("en_off_valid", 32'(out_valid), 32'd1);
        chk("en_off_port", 32'(port), 32'd3);
        en = 1'b1;
        in_valid = 1'b0;
        tick();
        chk("en_on_drain", 32'(port), 32'd7);

`ifdef ROUTE_DST_CHECK_EN
        m3_exp_port = 3'd0;
        m3_exp_err  = 1'b1;
`else
        m3_exp_port = 3'd1;
        m3_exp_err  = 1'b0;
`endif
        flit(1'b1, 1'b1, 2'd3, 1'd0);
        tick();
        chk("oom_4x2_port", 32'(port), 32'd1);
        chk("oom_4x2_err", 32'(err), 32'd0);
        chk("oom_3x2_port", 32'(m3_port), 32'(m3_exp_port));
        chk("oom_3x2_err", 32'(m3_err), 32'(m3_exp_err));
        in_valid = 1'b0;
        tick();
        chk("oom_3x2_err_clear", 32'(m3_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
